min_mem_arbiter: RTL and testbench

- Arbitrates the single shared instruction/data memory port of the MIN execution unit between two requesters: the fetch path (loads IRF) and the data path (DI loads, DO stores).
- Sits between the execution-unit control FSM and the memory array. It serialises accesses, tracks one outstanding transaction, times out hung accesses and reports completion to the owning requester.

---
 rtl/min_mem_arbiter_if.sv | 44 ++++
 rtl/min_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_min_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_mem_arbiter_if.sv
// Signal bundle for min_mem_arbiter: fetch and data requester handshakes,
// the shared memory port and the status outputs.
interface min_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              timeout_sticky;

    // Arbiter side.
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata, err,
               mem_en, mem_we, mem_addr, mem_wdata, busy, timeout_sticky
    );

    // Requester / memory-array side.
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata, err,
               mem_en, mem_we, mem_addr, mem_wdata, busy, timeout_sticky
    );
endinterface

// File: rtl/min_mem_arbiter.sv
// Single-port memory arbiter between the MIN fetch and data paths; one access in flight.
// Define MIN_ARB_RR_EN for round-robin tie-breaking instead of data priority with starvation override.
module min_mem_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             reset,
    min_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state;
    logic [TCNT_W-1:0] tcnt;
    logic              owner_f;   // 1: fetch owns the current/last access
    logic              f_wins;

`ifdef MIN_ARB_RR_EN
    // A tie goes to whoever did not own the previous access; owner_f resets to data.
    always_comb f_wins = bus.f_req && (!bus.d_req || !owner_f);
`else
    localparam int                SCNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_MAX);

    logic [SCNT_W-1:0] starve_cnt;

    always_comb f_wins = bus.f_req && (!bus.d_req || starve_cnt >= SCNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE && (bus.f_req || bus.d_req)) begin
            if (f_wins)
                starve_cnt <= '0;
            else if (bus.f_req && starve_cnt < SCNT_MAX)
                starve_cnt <= starve_cnt + SCNT_W'(1);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            tcnt               <= '0;
            owner_f            <= 1'b0;
            bus.f_gnt          <= 1'b0;
            bus.f_done         <= 1'b0;
            bus.f_rdata        <= '0;
            bus.d_gnt          <= 1'b0;
            bus.d_done         <= 1'b0;
            bus.d_rdata        <= '0;
            bus.err            <= 1'b0;
            bus.mem_en         <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.busy           <= 1'b0;
            bus.timeout_sticky <= 1'b0;
        end else begin
            bus.f_gnt  <= 1'b0;
            bus.d_gnt  <= 1'b0;
            bus.f_done <= 1'b0;
            bus.d_done <= 1'b0;
            bus.err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        state      <= BUSY;
                        bus.busy   <= 1'b1;
                        bus.mem_en <= 1'b1;
                        tcnt       <= '0;
                        owner_f    <= f_wins;
                        if (f_wins) begin
                            bus.f_gnt     <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.f_addr;
                            bus.mem_wdata <= '0;
                        end else begin
                            bus.d_gnt     <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end
                    end
                end

                BUSY: begin
                    if (bus.mem_ack || tcnt == TCNT_LAST) begin
                        state      <= DONE;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        bus.f_done <= owner_f;
                        bus.d_done <= !owner_f;
                        // An ack on the last allowed cycle still counts as a completion.
                        if (bus.mem_ack) begin
                            if (owner_f)
                                bus.f_rdata <= bus.mem_rdata;
                            else if (!bus.mem_we)
                                bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.err            <= 1'b1;
                            bus.timeout_sticky <= 1'b1;
                            if (owner_f)
                                bus.f_rdata <= '0;
                            else
                                bus.d_rdata <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    bus.busy   <= 1'b0;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_min_mem_arbiter.sv
// Self-checking bench for min_mem_arbiter: vector table, grant/done monitor with
// per-requester scoreboards, and hand-written tie, starvation, timeout and reset sequences.
module tb_min_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 16;

    typedef struct {
        logic        is_f;
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        int          ack_dly;    // BUSY cycle index carrying the ack; -1 = never
        logic [15:0] exp_rdata;  // owner's rdata after done
        int          exp_lat;    // cycles from gnt to done
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    min_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    min_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT_CYC(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    sb_t  f_q[$];
    sb_t  d_q[$];
    logic prev_gnt = 1'b0;

    // Memory model: acks in BUSY cycle ack_dly, stores land on the ack.
    logic        model_ack;
    logic [15:0] model_rdata;
    logic        late_ack = 1'b0;
    int          ack_dly  = 0;
    logic [15:0] mem [32];

    assign bus.mem_ack   = model_ack | late_ack;
    assign bus.mem_rdata = late_ack ? 16'hDEAD : model_rdata;

    initial begin : mem_model
        int c;
        c           = 0;
        model_ack   = 1'b0;
        model_rdata = 16'h0000;
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
        mem[6] = 16'h1234;
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (bus.mem_en) begin
                if (ack_dly >= 0 && c == ack_dly) begin
                    model_ack   = 1'b1;
                    model_rdata = mem[bus.mem_addr];
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                end
                c++;
            end else begin
                c = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outputs_vec();
        return 64'({bus.f_gnt, bus.f_done, bus.f_rdata, bus.d_gnt, bus.d_done, bus.d_rdata,
                    bus.err, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    bus.busy, bus.timeout_sticky});
    endfunction

    task automatic monitor();
        sb_t  e;
        logic g;
        g = bus.f_gnt | bus.d_gnt;
        if (g) begin
            check("gnt_single_cycle", 64'(prev_gnt), 64'd0);
            check("gnt_exclusive", 64'(bus.f_gnt & bus.d_gnt), 64'd0);
            check("gnt_mem_en", 64'(bus.mem_en), 64'd1);
            check("gnt_mem_addr", 64'(bus.mem_addr), 64'(bus.f_gnt ? bus.f_addr : bus.d_addr));
            check("gnt_mem_we", 64'(bus.mem_we), 64'(bus.f_gnt ? 1'b0 : bus.d_we));
            if (bus.d_gnt && bus.d_we)
                check("gnt_mem_wdata", 64'(bus.mem_wdata), 64'(bus.d_wdata));
        end
        prev_gnt = g;
        if (bus.err && !bus.f_done && !bus.d_done)
            check("err_without_done", 64'd1, 64'd0);
        if (bus.f_done) begin
            if (f_q.size() == 0) check("f_done_unexpected", 64'd1, 64'd0);
            else begin
                e = f_q.pop_front();
                check("f_rdata", 64'(bus.f_rdata), 64'(e.rdata));
                check("f_err", 64'(bus.err), 64'(e.err));
            end
        end
        if (bus.d_done) begin
            if (d_q.size() == 0) check("d_done_unexpected", 64'd1, 64'd0);
            else begin
                e = d_q.pop_front();
                check("d_rdata", 64'(bus.d_rdata), 64'(e.rdata));
                check("d_err", 64'(bus.err), 64'(e.err));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset) monitor();
    endtask

    task automatic start_req(input logic is_f, input logic we, input logic [4:0] addr,
                             input logic [15:0] wdata);
        if (is_f) begin
            bus.f_req  = 1'b1;
            bus.f_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end
    endtask

    task automatic wait_gnt(output int n, output logic is_f);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.f_gnt || bus.d_gnt) && n < 20);
        if (!(bus.f_gnt || bus.d_gnt)) check("gnt_wait_expired", 64'd0, 64'd1);
        is_f = bus.f_gnt;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.f_done || bus.d_done) && n < 40);
        if (!(bus.f_done || bus.d_done)) check("done_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin : main
        vec_t vecs [8];
        int   n;
        int   m;
        logic gf;
        logic exp_f;

        vecs[0] = '{1'b1, 1'b0, 5'd6,  16'h0000, 2, 16'h1234, 3};
        vecs[1] = '{1'b0, 1'b0, 5'd3,  16'h0000, 0, 16'h1003, 1};
        vecs[2] = '{1'b0, 1'b1, 5'd3,  16'hCAFE, 1, 16'h1003, 2};
        vecs[3] = '{1'b0, 1'b0, 5'd3,  16'h0000, 0, 16'hCAFE, 1};
        vecs[4] = '{1'b1, 1'b0, 5'd31, 16'h0000, 4, 16'h101F, 5};
        vecs[5] = '{1'b1, 1'b0, 5'd0,  16'h0000, 0, 16'h1000, 1};
        vecs[6] = '{1'b0, 1'b1, 5'd31, 16'h5A5A, 3, 16'hCAFE, 4};
        vecs[7] = '{1'b1, 1'b0, 5'd31, 16'h0000, 1, 16'h5A5A, 2};

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 6; i++) begin
            bus.f_req   = 1'($urandom);
            bus.f_addr  = 5'($urandom);
            bus.d_req   = 1'($urandom);
            bus.d_we    = 1'($urandom);
            bus.d_addr  = 5'($urandom);
            bus.d_wdata = 16'($urandom);
            late_ack    = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset_outputs%0d", i), outputs_vec(), 64'd0);
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        late_ack  = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 64'(bus.busy), 64'd0);
        end

        // Single accesses from the vector table.
        for (int i = 0; i < 8; i++) begin
            ack_dly = vecs[i].ack_dly;
            start_req(vecs[i].is_f, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].is_f) f_q.push_back('{vecs[i].exp_rdata, 1'b0});
            else              d_q.push_back('{vecs[i].exp_rdata, 1'b0});
            wait_gnt(n, gf);
            check($sformatf("vec%0d_gnt_lat", i), 64'(n), 64'd1);
            check($sformatf("vec%0d_owner", i), 64'(gf), 64'(vecs[i].is_f));
            bus.f_req = 1'b0;
            bus.d_req = 1'b0;
            wait_done(m);
            check($sformatf("vec%0d_done_lat", i), 64'(m), 64'(vecs[i].exp_lat));
            tick();
            check($sformatf("vec%0d_idle", i), 64'(bus.busy), 64'd0);
        end

        // Tie: data store wins, fetch follows on the next IDLE.
        ack_dly = 1;
        start_req(1'b1, 1'b0, 5'd6, 16'h0000);
        start_req(1'b0, 1'b1, 5'd1, 16'hBEEF);
        d_q.push_back('{16'hCAFE, 1'b0});
        f_q.push_back('{16'h1234, 1'b0});
        wait_gnt(n, gf);
        check("tie_first_data", 64'(gf), 64'd0);
        check("tie_mem_we", 64'(bus.mem_we), 64'd1);
        check("tie_mem_wdata", 64'(bus.mem_wdata), 64'hBEEF);
        bus.d_req = 1'b0;
        wait_gnt(n, gf);
        check("tie_second_fetch", 64'(gf), 64'd1);
        check("tie_gap", 64'(n), 64'd4);
        bus.f_req = 1'b0;
        wait_done(m);
        tick();

        // Both held continuously: starvation override (or alternation under round-robin).
        ack_dly = 0;
        start_req(1'b1, 1'b0, 5'd5, 16'h0000);
        start_req(1'b0, 1'b0, 5'd2, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            wait_gnt(n, gf);
`ifdef MIN_ARB_RR_EN
            exp_f = (i % 2) == 1;
`else
            exp_f = (i % 5) == 4;
`endif
            check($sformatf("starve_gnt%0d", i), 64'(gf), 64'(exp_f));
            if (gf) f_q.push_back('{16'h1005, 1'b0});
            else    d_q.push_back('{16'h1002, 1'b0});
            if (i == 9) begin
                bus.f_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        wait_done(m);
        tick();

        // Timeout on a data load, then late acks in DONE and IDLE are ignored.
        ack_dly = -1;
        start_req(1'b0, 1'b0, 5'd4, 16'h0000);
        d_q.push_back('{16'h0000, 1'b1});
        wait_gnt(n, gf);
        bus.d_req = 1'b0;
        wait_done(m);
        check("timeout_lat", 64'(m), 64'd15);
        check("timeout_sticky_set", 64'(bus.timeout_sticky), 64'd1);
        late_ack = 1'b1;
        tick();
        tick();
        late_ack = 1'b0;
        tick();
        check("late_ack_d_rdata", 64'(bus.d_rdata), 64'd0);
        check("late_ack_f_rdata", 64'(bus.f_rdata), 64'h1005);
        check("late_ack_busy", 64'(bus.busy), 64'd0);

        ack_dly = 1;
        start_req(1'b1, 1'b0, 5'd0, 16'h0000);
        f_q.push_back('{16'h1000, 1'b0});
        wait_gnt(n, gf);
        bus.f_req = 1'b0;
        wait_done(m);
        tick();
        check("sticky_holds", 64'(bus.timeout_sticky), 64'd1);

        // Reset in the middle of an access aborts it with no done.
        ack_dly = -1;
        start_req(1'b0, 1'b0, 5'd7, 16'h0000);
        wait_gnt(n, gf);
        bus.d_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midreset_outputs", outputs_vec(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("midreset_busy", 64'(bus.busy), 64'd0);

        check("f_queue_drained", 64'(f_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
